// File: rtl/uart8.sv
// uart8: 8N1 UART (8 data bits, no parity, 1 stop bit, LSB first, line idles high).
// The receiver and transmitter run independently on one clock. The receiver samples
// on a free-running 16x baud tick. The transmitter times each bit directly in clocks.
// Optional build macro: UART8_RX_SYNC_EN passes rx through a 2-flop synchronizer
// (reset to 1) before the receiver. This adds 2 clks of latency to every rx decision.
// Ports:
//   clk, resetN         system clock (rising edge), asynchronous active-low reset
//   rxEn, rx            receiver enable, serial input
//   rxBusy/rxDone/rxErr receive in progress, 1-clk byte-valid pulse, framing error
//   out[7:0]            last correctly received byte
//   txEn, txStart, in   transmitter enable, send request, byte to send
//   txBusy/txDone, tx   transmit in progress, 1-clk end-of-frame pulse, serial output
module uart8 #(
    parameter int unsigned CLOCK_RATE = 12000000,
    parameter int unsigned BAUD_RATE  = 9600
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       rxEn,
    input  logic       rx,
    output logic       rxBusy,
    output logic       rxDone,
    output logic       rxErr,
    output logic [7:0] out,
    input  logic       txEn,
    input  logic       txStart,
    input  logic [7:0] in,
    output logic       txBusy,
    output logic       txDone,
    output logic       tx
);

    localparam int unsigned RX_DIV = CLOCK_RATE / (BAUD_RATE * 16);
    localparam int unsigned TX_DIV = CLOCK_RATE / BAUD_RATE;
    localparam int unsigned RXDW   = $clog2(RX_DIV + 1);
    localparam int unsigned TXDW   = $clog2(TX_DIV + 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    // Free-running 16x oversampling tick
    logic [RXDW-1:0] div_cnt;
    logic            tick_c;

    assign tick_c = (div_cnt == RXDW'(RX_DIV - 1));

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)     div_cnt <= '0;
        else if (tick_c) div_cnt <= '0;
        else             div_cnt <= div_cnt + RXDW'(1);
    end

    // Receiver input, optionally synchronized
    logic rx_s;
`ifdef UART8_RX_SYNC_EN
    logic [1:0] rx_sync;
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) rx_sync <= 2'b11;
        else         rx_sync <= {rx_sync[0], rx};
    end
    assign rx_s = rx_sync[1];
`else
    assign rx_s = rx;
`endif

    // Receiver state and datapath registers
    rx_state_t  rx_state, rx_state_n;
    logic [3:0] rx_tcnt, rx_tcnt_n;
    logic [2:0] rx_bcnt, rx_bcnt_n;
    logic [7:0] rx_shift, rx_shift_n;
    logic       rx_busy_n, rx_done_n, rx_err_n;
    logic [7:0] out_n;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rx_state <= RX_IDLE;
            rx_tcnt  <= '0;
            rx_bcnt  <= '0;
            rx_shift <= '0;
            rxBusy   <= 1'b0;
            rxDone   <= 1'b0;
            rxErr    <= 1'b0;
            out      <= 8'h00;
        end else begin
            rx_state <= rx_state_n;
            rx_tcnt  <= rx_tcnt_n;
            rx_bcnt  <= rx_bcnt_n;
            rx_shift <= rx_shift_n;
            rxBusy   <= rx_busy_n;
            rxDone   <= rx_done_n;
            rxErr    <= rx_err_n;
            out      <= out_n;
        end
    end

    // Receiver next state: sample mid start bit, then every 16 ticks
    always_comb begin
        rx_state_n = rx_state;
        rx_tcnt_n  = rx_tcnt;
        rx_bcnt_n  = rx_bcnt;
        rx_shift_n = rx_shift;
        rx_busy_n  = rxBusy;
        rx_done_n  = 1'b0;
        rx_err_n   = rxErr;
        out_n      = out;
        case (rx_state)
            RX_IDLE: begin
                if (rxEn && !rx_s && tick_c) begin
                    rx_state_n = RX_START;
                    rx_busy_n  = 1'b1;
                    rx_err_n   = 1'b0;
                    rx_tcnt_n  = '0;
                end
            end
            RX_START: begin
                if (tick_c) begin
                    if (rx_tcnt == 4'd7) begin
                        rx_tcnt_n = '0;
                        rx_bcnt_n = '0;
                        if (!rx_s) begin
                            rx_state_n = RX_DATA;
                        end else begin
                            rx_state_n = RX_IDLE;
                            rx_busy_n  = 1'b0;
                        end
                    end else begin
                        rx_tcnt_n = rx_tcnt + 4'd1;
                    end
                end
            end
            RX_DATA: begin
                if (tick_c) begin
                    rx_tcnt_n = rx_tcnt + 4'd1;
                    if (rx_tcnt == 4'd15) begin
                        rx_shift_n = {rx_s, rx_shift[7:1]};
                        rx_bcnt_n  = rx_bcnt + 3'd1;
                        if (rx_bcnt == 3'd7) rx_state_n = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (tick_c) begin
                    rx_tcnt_n = rx_tcnt + 4'd1;
                    if (rx_tcnt == 4'd15) begin
                        if (rx_s) begin
                            out_n     = rx_shift;
                            rx_done_n = 1'b1;
                        end else begin
                            rx_err_n  = 1'b1;
                        end
                        rx_state_n = RX_IDLE;
                        rx_busy_n  = 1'b0;
                    end
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
        // Disabling the receiver abandons any frame in progress
        if (!rxEn && (rx_state != RX_IDLE)) begin
            rx_state_n = RX_IDLE;
            rx_busy_n  = 1'b0;
            rx_done_n  = 1'b0;
            rx_err_n   = rxErr;
            out_n      = out;
        end
    end

    // Transmitter state and datapath registers
    tx_state_t       tx_state, tx_state_n;
    logic [TXDW-1:0] tx_cnt, tx_cnt_n;
    logic [2:0]      tx_bcnt, tx_bcnt_n;
    logic [7:0]      tx_shift, tx_shift_n;
    logic            tx_n, tx_busy_n, tx_done_n;
    logic            bit_end_c;

    assign bit_end_c = (tx_cnt == TXDW'(TX_DIV - 1));

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bcnt  <= '0;
            tx_shift <= '0;
            tx       <= 1'b1;
            txBusy   <= 1'b0;
            txDone   <= 1'b0;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bcnt  <= tx_bcnt_n;
            tx_shift <= tx_shift_n;
            tx       <= tx_n;
            txBusy   <= tx_busy_n;
            txDone   <= tx_done_n;
        end
    end

    // Transmitter next state: the start bit begins on the accepting clock
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_bcnt_n  = tx_bcnt;
        tx_shift_n = tx_shift;
        tx_n       = tx;
        tx_busy_n  = txBusy;
        tx_done_n  = 1'b0;
        if (tx_state == TX_IDLE) begin
            if (txEn && txStart) begin
                tx_state_n = TX_START;
                tx_shift_n = in;
                tx_n       = 1'b0;
                tx_busy_n  = 1'b1;
                tx_cnt_n   = '0;
            end
        end else if (!bit_end_c) begin
            tx_cnt_n = tx_cnt + TXDW'(1);
        end else begin
            tx_cnt_n = '0;
            case (tx_state)
                TX_START: begin
                    tx_n       = tx_shift[0];
                    tx_shift_n = {1'b0, tx_shift[7:1]};
                    tx_bcnt_n  = '0;
                    tx_state_n = TX_DATA;
                end
                TX_DATA: begin
                    if (tx_bcnt == 3'd7) begin
                        tx_n       = 1'b1;
                        tx_state_n = TX_STOP;
                    end else begin
                        tx_n       = tx_shift[0];
                        tx_shift_n = {1'b0, tx_shift[7:1]};
                        tx_bcnt_n  = tx_bcnt + 3'd1;
                    end
                end
                TX_STOP: begin
                    tx_state_n = TX_IDLE;
                    tx_busy_n  = 1'b0;
                    tx_done_n  = 1'b1;
                end
                default: tx_state_n = TX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart8.sv
// tb_uart8: directed self-checking bench for uart8 at 12 MHz / 9600 baud.
// Inputs change on falling clock edges, and outputs are sampled on falling edges.
`timescale 1ns/1ps
module tb_uart8;

    localparam int RX_DIV  = 78;
    localparam int BIT_CLK = 1250;

    logic       clk = 1'b0;
    logic       resetN;
    logic       rxEn, rx, rxBusy, rxDone, rxErr;
    logic [7:0] out;
    logic       txEn, txStart, txBusy, txDone, tx;
    logic [7:0] in;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    bit err_seen = 1'b0;

    uart8 #(.CLOCK_RATE(12000000), .BAUD_RATE(9600)) dut (
        .clk(clk), .resetN(resetN),
        .rxEn(rxEn), .rx(rx), .rxBusy(rxBusy), .rxDone(rxDone), .rxErr(rxErr), .out(out),
        .txEn(txEn), .txStart(txStart), .in(in), .txBusy(txBusy), .txDone(txDone), .tx(tx)
    );

    always #41.667 clk = ~clk;

    // Pulse and error monitors
    always @(negedge clk) begin
        if (rxDone) done_cnt++;
        if (rxErr)  err_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one frame; 'spent' clocks of the start bit have already elapsed
    task automatic send_frame(input logic [7:0] b, input int bit_clks, input logic stop_val,
                              input int stop_clks, input int spent);
        rx = 1'b0;
        repeat (bit_clks - spent) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (bit_clks) @(negedge clk);
        end
        rx = stop_val;
        repeat (stop_clks) @(negedge clk);
        rx = 1'b1;
    endtask

    initial begin
        int         d0;
        int         lat;
        logic [9:0] tx_exp;

        resetN = 1'b0; rxEn = 1'b1; rx = 1'b1; txEn = 1'b1; txStart = 1'b0; in = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_tx",     32'(tx),     32'd1);
        check("rst_rxbusy", 32'(rxBusy), 32'd0);
        check("rst_out",    32'(out),    32'h00);
        check("rst_txbusy", 32'(txBusy), 32'd0);
        resetN = 1'b1;
        repeat (5) @(negedge clk);

        // Glitch: 16 us low looks like a start, then dies at mid-bit
        d0 = done_cnt;
        rx = 1'b0;
        repeat (192) @(negedge clk);
        check("glitch_busy_rise", 32'(rxBusy), 32'd1);
        rx = 1'b1;
        repeat (1200) @(negedge clk);
        check("glitch_busy_fall", 32'(rxBusy), 32'd0);
        check("glitch_no_done",   32'(done_cnt - d0), 32'd0);
        check("glitch_no_err",    32'(rxErr), 32'd0);

        // 8'h56 at 107.5 us per bit (about 3.2% slow)
        d0 = done_cnt;
        send_frame(8'h56, 1290, 1'b1, 1290, 0);
        repeat (200) @(negedge clk);
        check("slow_out",   32'(out), 32'h56);
        check("slow_done",  32'(done_cnt - d0), 32'd1);
        check("slow_err",   32'(rxErr), 32'd0);
        check("slow_busy",  32'(rxBusy), 32'd0);

        // 8'h56 with the stop bit held low: framing error, out unchanged
        d0 = done_cnt;
        err_seen = 1'b0;
        send_frame(8'h56, BIT_CLK, 1'b0, BIT_CLK, 0);
        repeat (1300) @(negedge clk);
        check("ferr_err",  32'(err_seen), 32'd1);
        check("ferr_done", 32'(done_cnt - d0), 32'd0);
        check("ferr_out",  32'(out), 32'h56);
        check("ferr_busy", 32'(rxBusy), 32'd0);

        // Receiver disabled mid-frame
        d0 = done_cnt;
        rx = 1'b0;
        repeat (2000) @(negedge clk);
        check("abort_busy_pre", 32'(rxBusy), 32'd1);
        rxEn = 1'b0;
        @(negedge clk);
        check("abort_busy_post", 32'(rxBusy), 32'd0);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        rxEn = 1'b1;
        repeat (1500) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        check("abort_out",     32'(out), 32'h56);

        // Back-to-back: stop high only 71 us, then the next start edge
        d0 = done_cnt;
        send_frame(8'h3C, BIT_CLK, 1'b1, 852, 0);
        check("b2b_a_out",  32'(out), 32'h3C);
        check("b2b_a_done", 32'(done_cnt - d0), 32'd1);
        check("b2b_a_idle", 32'(rxBusy), 32'd0);
        rx = 1'b0;
        lat = 0;
        while (!rxBusy && lat <= RX_DIV + 2) begin
            @(negedge clk);
            lat++;
        end
        check("b2b_busy_lat", 32'(lat <= RX_DIV), 32'd1);
        send_frame(8'hC3, BIT_CLK, 1'b1, BIT_CLK, lat);
        repeat (100) @(negedge clk);
        check("b2b_b_out",  32'(out), 32'hC3);
        check("b2b_b_done", 32'(done_cnt - d0), 32'd2);

        // Transmit 8'hA5: start, LSB first, stop
        tx_exp = 10'b11_1010_0101 << 1;
        tx_exp[9] = 1'b1;
        in = 8'hA5; txStart = 1'b1;
        @(negedge clk);
        txStart = 1'b0;
        check("tx_busy_rise", 32'(txBusy), 32'd1);
        repeat (625) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("tx_bit%0d", k), 32'(tx), 32'(tx_exp[k]));
            if (k == 3) begin
                // A request while busy is ignored
                in = 8'hFF; txStart = 1'b1;
                @(negedge clk);
                txStart = 1'b0;
                repeat (BIT_CLK - 1) @(negedge clk);
            end else if (k < 9) begin
                repeat (BIT_CLK) @(negedge clk);
            end
        end
        lat = 0;
        while (!txDone && lat < 700) begin
            @(negedge clk);
            lat++;
        end
        check("tx_done_time", 32'(lat), 32'd625);
        check("tx_busy_fall", 32'(txBusy), 32'd0);
        @(negedge clk);
        check("tx_done_pulse", 32'(txDone), 32'd0);
        check("tx_idle_line",  32'(tx), 32'd1);

        // Reset in the middle of both a receive and a transmit
        in = 8'h0F; txStart = 1'b1; rx = 1'b0;
        @(negedge clk);
        txStart = 1'b0;
        repeat (3000) @(negedge clk);
        check("mid_txbusy", 32'(txBusy), 32'd1);
        check("mid_rxbusy", 32'(rxBusy), 32'd1);
        resetN = 1'b0;
        #1;
        check("mid_rst_tx",     32'(tx),     32'd1);
        check("mid_rst_txbusy", 32'(txBusy), 32'd0);
        check("mid_rst_rxbusy", 32'(rxBusy), 32'd0);
        check("mid_rst_out",    32'(out),    32'h00);
        check("mid_rst_flags",  32'({rxDone, rxErr, txDone}), 32'd0);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        resetN = 1'b1;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
